// File: rtl/multi_cycle_data_path.sv
// rtl/multi_cycle_data_path.sv - multi-cycle MIPS-subset datapath and controller
module multi_cycle_data_path #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [2:0]            state,
    output logic                  halted,
    output logic [31:0]           retired
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t cur_state;
    state_t nxt_state;

    // architectural and holding registers
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [31:0]           ir_reg;
    logic [31:0]           a_reg;
    logic [31:0]           b_reg;
    logic [31:0]           alu_out_reg;
    logic [31:0]           mdr_reg;
    logic [31:0]           regs [32];
    logic [31:0]           retired_cnt;

    // instruction fields, always taken from IR
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] target;
    logic [31:0] imm_sext;

    assign opcode   = ir_reg[31:26];
    assign rs       = ir_reg[25:21];
    assign rt       = ir_reg[20:16];
    assign rd       = ir_reg[15:11];
    assign funct    = ir_reg[5:0];
    assign target   = ir_reg[25:0];
    assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

    logic is_alu_r;
    logic is_jr;
    logic is_addi;
    logic is_beq;
    logic is_lw;
    logic is_sw;
    logic is_j;
    logic is_jal;
    logic is_illegal;

    // instruction class decode; anything outside the supported set halts the core
    always_comb begin
        is_alu_r   = (opcode == OP_RTYPE) &&
                     (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
        is_jr      = (opcode == OP_RTYPE) && (funct == FN_JR);
        is_addi    = (opcode == OP_ADDI);
        is_beq     = (opcode == OP_BEQ);
        is_lw      = (opcode == OP_LW);
        is_sw      = (opcode == OP_SW);
        is_j       = (opcode == OP_J);
        is_jal     = (opcode == OP_JAL);
        is_illegal = !(is_alu_r || is_jr || is_addi || is_beq ||
                       is_lw || is_sw || is_j || is_jal);
    end

    // register file read ports; r0 is hardwired to zero
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

    logic [31:0] alu_b;
    logic [5:0]  alu_fn;
    logic [31:0] alu_result;

    // ALU: R-type follows funct, every immediate form (addi, lw/sw address) adds
    always_comb begin
        alu_b  = is_alu_r ? b_reg : imm_sext;
        alu_fn = is_alu_r ? funct : FN_ADD;
        case (alu_fn)
            FN_ADD:  alu_result = a_reg + alu_b;
            FN_SUB:  alu_result = a_reg - alu_b;
            FN_AND:  alu_result = a_reg & alu_b;
            FN_OR:   alu_result = a_reg | alu_b;
            FN_SLT:  alu_result = {31'd0, ($signed(a_reg) < $signed(alu_b))};
            default: alu_result = a_reg + alu_b;
        endcase
    end

    // PC targets are formed at 32 bits and truncated to the address width
    logic [31:0]           pc_ext;
    logic [31:0]           jump_target;
    logic [31:0]           branch_target;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    assign pc_ext        = 32'(pc_reg);
    assign jump_target   = {pc_ext[31:28], target, 2'b00};
    assign branch_target = pc_ext + (imm_sext << 2);
    assign pc_plus4      = pc_reg + ADDR_WIDTH'(32'd4);

    // datapath control, produced by the output process
    logic                  ir_we;
    logic                  pc_we;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  ab_we;
    logic                  alu_we;
    logic                  mdr_we;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [31:0]           rf_wdata;
    logic                  retire;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // next-state logic; mem_ready only matters in the two requesting states
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
                    nxt_state = S_HALT;
                end else if (is_j || is_jal || is_jr) begin
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_beq) begin
                    nxt_state = S_FETCH;
                end else if (is_lw || is_sw) begin
                    nxt_state = S_MEMORY;
                end else begin
                    nxt_state = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    nxt_state = is_lw ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: nxt_state = S_FETCH;
            S_HALT:      nxt_state = S_HALT;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // outputs and datapath enables; request outputs depend only on state and
    // registers that are frozen while the request waits, so they stay stable
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = pc_reg;
        mem_wdata = 32'd0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_next   = pc_reg;
        ab_we     = 1'b0;
        alu_we    = 1'b0;
        mdr_we    = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        retire    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_next = pc_plus4;
                end
            end
            S_DECODE: begin
                ab_we = !is_illegal;
                if (is_j || is_jal) begin
                    pc_we   = 1'b1;
                    pc_next = jump_target[ADDR_WIDTH-1:0];
                    retire  = 1'b1;
                end
                if (is_jal) begin
                    rf_we    = 1'b1;
                    rf_waddr = 5'd31;
                    rf_wdata = pc_ext;
                end
                if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_next = rs_val[ADDR_WIDTH-1:0];
                    retire  = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (is_beq) begin
                    retire = 1'b1;
                    if (a_reg == b_reg) begin
                        pc_we   = 1'b1;
                        pc_next = branch_target[ADDR_WIDTH-1:0];
                    end
                end else begin
                    alu_we = 1'b1;
                end
            end
            S_MEMORY: begin
                mem_addr = alu_out_reg[ADDR_WIDTH-1:0];
                if (is_lw) begin
                    mem_rd = 1'b1;
                    mdr_we = mem_ready;
                end else begin
                    mem_wr    = 1'b1;
                    mem_wdata = b_reg;
                    retire    = mem_ready;
                end
            end
            S_WRITEBACK: begin
                rf_we    = 1'b1;
                rf_waddr = is_alu_r ? rd : rt;
                rf_wdata = is_lw ? mdr_reg : alu_out_reg;
                retire   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC, IR and the holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= RESET_PC;
            ir_reg      <= 32'd0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            alu_out_reg <= 32'd0;
            mdr_reg     <= 32'd0;
        end else begin
            if (ir_we) begin
                ir_reg <= mem_rdata;
            end
            if (pc_we) begin
                pc_reg <= pc_next;
            end
            if (ab_we) begin
                a_reg <= rs_val;
                b_reg <= rt_val;
            end
            if (alu_we) begin
                alu_out_reg <= alu_result;
            end
            if (mdr_we) begin
                mdr_reg <= mem_rdata;
            end
        end
    end

    // register file write port; writes to r0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_cnt <= 32'd0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    assign state   = cur_state;
    assign halted  = (cur_state == S_HALT);
    assign retired = retired_cnt;

endmodule

// File: tb/tb_multi_cycle_data_path.sv
// tb/tb_multi_cycle_data_path.sv - randomized bench with ISA-level reference model
module tb_multi_cycle_data_path;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] retired;

    multi_cycle_data_path dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .state     (state),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] bench_mem [1024];
    logic [31:0] m_mem     [1024];
    logic [31:0] m_regs    [32];
    logic [31:0] m_pc;
    logic [31:0] m_retired;

    bit          req_active;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_rd;
    logic        c_wr;
    int          wait_left;
    int          waits_acc;
    int          min_wait;
    int          max_wait;
    bit          first_req_seen;
    logic [31:0] first_req_addr;
    int          n_stores;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    int          last_cyc;
    int          k;
    int          r;
    int          skip;
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    localparam logic [31:0] NOP = 32'h2000_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int word_idx);
        return {op, 26'(word_idx)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) bench_mem[i] = NOP;
    endtask

    task automatic sync_mem();
        for (int i = 0; i < 1024; i++) m_mem[i] = bench_mem[i];
    endtask

    task automatic model_reset();
        m_pc      = 32'd0;
        m_retired = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic wreg(input int idx, input logic [31:0] v);
        if (idx != 0) m_regs[idx] = v;
    endtask

    // one instruction of the ISA: architectural effect plus its nominal cycle cost
    task automatic model_step(output logic [31:0] e_pc, output int e_cyc, output bit e_store,
                              output logic [31:0] e_saddr, output logic [31:0] e_sdata, output bit e_halt);
        logic [31:0] ins, a, b, se, npc, ea;
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        ins = m_mem[m_pc[11:2]];
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        a   = m_regs[rs];
        b   = m_regs[rt];
        se  = {{16{ins[15]}}, ins[15:0]};
        e_pc = m_pc; npc = m_pc + 32'd4;
        e_store = 0; e_saddr = 0; e_sdata = 0; e_halt = 0; e_cyc = 0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin wreg(rd, a + b); e_cyc = 4; end
                    6'h22: begin wreg(rd, a - b); e_cyc = 4; end
                    6'h24: begin wreg(rd, a & b); e_cyc = 4; end
                    6'h25: begin wreg(rd, a | b); e_cyc = 4; end
                    6'h2A: begin wreg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0); e_cyc = 4; end
                    6'h08: begin npc = a; e_cyc = 2; end
                    default: e_halt = 1;
                endcase
            end
            6'h08: begin wreg(rt, a + se); e_cyc = 4; end
            6'h04: begin if (a == b) npc = npc + (se << 2); e_cyc = 3; end
            6'h23: begin ea = a + se; wreg(rt, m_mem[ea[11:2]]); e_cyc = 5; end
            6'h2B: begin
                ea = a + se; m_mem[ea[11:2]] = b;
                e_store = 1; e_saddr = ea; e_sdata = b; e_cyc = 4;
            end
            6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; e_cyc = 2; end
            6'h03: begin wreg(31, m_pc + 32'd4); npc = {npc[31:28], ins[25:0], 2'b00}; e_cyc = 2; end
            default: e_halt = 1;
        endcase
        if (!e_halt) begin
            m_pc = npc;
            m_retired = m_retired + 32'd1;
        end
    endtask

    // one clock: answer the memory request seen now, then advance to the next falling edge
    task automatic tick();
        bit rq;
        rq = mem_rd | mem_wr;
        if (state == 3'd1 || state == 3'd2 || state == 3'd4 || state == 3'd5)
            check("idle_req", 32'(rq), 32'd0);
        if (rq) begin
            check("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
            if (!req_active) begin
                req_active = 1;
                c_addr = mem_addr; c_rd = mem_rd; c_wr = mem_wr; c_wdata = mem_wdata;
                wait_left = int'($urandom_range(max_wait, min_wait));
                waits_acc += wait_left;
                if (!first_req_seen) begin
                    first_req_seen = 1;
                    first_req_addr = mem_addr;
                end
            end else begin
                check("req_stable", 32'(mem_addr == c_addr && mem_rd == c_rd && mem_wr == c_wr &&
                                        (!c_wr || mem_wdata == c_wdata)), 32'd1);
            end
            if (wait_left == 0) begin
                mem_ready  = 1'b1;
                mem_rdata  = mem_rd ? bench_mem[mem_addr[11:2]] : $urandom;
                if (mem_wr) begin
                    bench_mem[mem_addr[11:2]] = mem_wdata;
                    n_stores++;
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                end
                req_active = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            mem_ready  = 1'($urandom_range(1, 0));
            mem_rdata  = $urandom;
            req_active = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_instr();
        logic [31:0] e_pc, e_saddr, e_sdata, r_before;
        int          e_cyc, cyc;
        bit          e_store, e_halt;
        model_step(e_pc, e_cyc, e_store, e_saddr, e_sdata, e_halt);
        waits_acc = 0; first_req_seen = 0; first_req_addr = 32'hDEAD_BEEF; n_stores = 0;
        r_before = retired;
        cyc = 0;
        while (cyc < 80 && retired == r_before && state != 3'd5) begin
            tick();
            cyc++;
        end
        check("fetch_pc", first_req_addr, e_pc);
        if (e_halt) begin
            check("halt_state", 32'(state), 32'd5);
            check("halted", 32'(halted), 32'd1);
        end else begin
            check("cycles", 32'(cyc), 32'(e_cyc + waits_acc));
            check("retired", retired, m_retired);
            check("store_cnt", 32'(n_stores), e_store ? 32'd1 : 32'd0);
            if (e_store) begin
                check("store_addr", st_addr, e_saddr);
                check("store_data", st_data, e_sdata);
            end
        end
        last_cyc = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        req_active = 0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b0; mem_rdata = 32'd0; min_wait = 0; max_wait = 0;

        // first instruction from reset
        do_reset();
        clear_mem();
        bench_mem[0] = enc_i(6'h08, 0, 1, 16'd5);
        sync_mem();
        run_instr();
        check("first_cycles", 32'(last_cyc), 32'd4);
        check("first_retired", retired, 32'd1);
        check("first_next_pc", mem_addr, 32'd4);
        check("first_next_rd", 32'(mem_rd), 32'd1);
        run_instr();

        // overflow wrap and signed compare
        do_reset();
        clear_mem();
        bench_mem[0]   = enc_i(6'h23, 0, 1, 16'h0800);
        bench_mem[1]   = enc_i(6'h08, 0, 2, 16'd1);
        bench_mem[2]   = enc_r(1, 2, 3, 6'h20);
        bench_mem[3]   = enc_r(3, 1, 4, 6'h2A);
        bench_mem[4]   = enc_i(6'h2B, 0, 3, 16'h0810);
        bench_mem[5]   = enc_i(6'h2B, 0, 4, 16'h0814);
        bench_mem[512] = 32'h7FFF_FFFF;
        sync_mem();
        max_wait = 1;
        repeat (5) run_instr();
        check("add_wrap", st_data, 32'h8000_0000);
        run_instr();
        check("slt_signed", st_data, 32'd1);

        // store then load with three wait cycles per request
        do_reset();
        clear_mem();
        bench_mem[0] = enc_i(6'h08, 0, 1, 16'd5);
        bench_mem[1] = enc_j(6'h02, 4);
        bench_mem[4] = enc_i(6'h2B, 0, 1, 16'd8);
        bench_mem[5] = enc_i(6'h23, 0, 5, 16'd8);
        bench_mem[6] = enc_i(6'h2B, 0, 5, 16'h0850);
        sync_mem();
        min_wait = 3; max_wait = 3;
        repeat (3) run_instr();
        check("sw_addr", st_addr, 32'd8);
        check("sw_data", st_data, 32'd5);
        run_instr();
        check("lw_cycles", 32'(last_cyc), 32'd11);
        run_instr();
        check("lw_value", st_data, 32'd5);

        // branch-to-self loop
        do_reset();
        clear_mem();
        bench_mem[4] = enc_i(6'h04, 0, 0, 16'hFFFF);
        sync_mem();
        min_wait = 0; max_wait = 0;
        repeat (4) run_instr();
        repeat (3) begin
            run_instr();
            check("beq_loop_pc", first_req_addr, 32'h10);
            check("beq_cycles", 32'(last_cyc), 32'd3);
        end

        // jump, jal link value, jr return
        do_reset();
        clear_mem();
        bench_mem[0]  = enc_j(6'h02, 8);
        bench_mem[8]  = enc_j(6'h03, 16);
        bench_mem[16] = enc_i(6'h2B, 0, 31, 16'h0840);
        bench_mem[17] = enc_r(31, 0, 0, 6'h08);
        bench_mem[9]  = enc_i(6'h2B, 0, 31, 16'h0844);
        sync_mem();
        run_instr();
        check("j_cycles", 32'(last_cyc), 32'd2);
        run_instr();
        check("jal_cycles", 32'(last_cyc), 32'd2);
        run_instr();
        check("jal_link", st_data, 32'h24);
        run_instr();
        run_instr();
        check("jr_target", first_req_addr, 32'h24);

        // illegal opcode halts until reset
        do_reset();
        clear_mem();
        bench_mem[0] = enc_i(6'h08, 0, 1, 16'd3);
        bench_mem[1] = 32'hFC00_0000;
        sync_mem();
        max_wait = 2;
        run_instr();
        run_instr();
        repeat (8) begin
            tick();
            check("halt_hold", 32'(state), 32'd5);
            check("halt_retired", retired, m_retired);
        end
        do_reset();
        check("post_halt_addr", mem_addr, 32'd0);
        check("post_halt_rd", 32'(mem_rd), 32'd1);

        // reset while a load is waiting in MEMORY
        clear_mem();
        bench_mem[0]   = enc_i(6'h08, 0, 5, 16'd7);
        bench_mem[1]   = enc_i(6'h23, 0, 5, 16'h0800);
        bench_mem[512] = 32'h0000_1234;
        sync_mem();
        min_wait = 0; max_wait = 0;
        run_instr();
        min_wait = 20; max_wait = 20;
        k = 0;
        while (!(state == 3'd3 && mem_rd) && k < 40) begin
            tick();
            k++;
        end
        check("lw_waiting", 32'(state), 32'd3);
        tick();
        tick();
        do_reset();
        clear_mem();
        bench_mem[0] = enc_i(6'h2B, 0, 5, 16'h0830);
        sync_mem();
        min_wait = 0; max_wait = 0;
        run_instr();
        check("abandoned_lw_reg", st_data, 32'd0);
        check("abandoned_lw_retired", retired, 32'd1);

        // random forward-flowing program
        do_reset();
        clear_mem();
        for (int i = 0; i < 512; i++) begin
            r    = int'($urandom_range(10, 0));
            skip = int'($urandom_range(2, 0));
            case (r)
                0, 1, 2, 3: bench_mem[i] = enc_r(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                                                 int'($urandom_range(7, 0)), fns[$urandom_range(4, 0)]);
                4:       bench_mem[i] = enc_i(6'h08, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 16'($urandom));
                5, 10:   bench_mem[i] = enc_i(6'h2B, 0, int'($urandom_range(7, 0)), 16'(32'h800 + 4 * $urandom_range(63, 0)));
                6:       bench_mem[i] = enc_i(6'h23, 0, int'($urandom_range(7, 0)), 16'(32'h800 + 4 * $urandom_range(63, 0)));
                7:       bench_mem[i] = enc_i(6'h04, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 16'(skip));
                8:       bench_mem[i] = enc_j(6'h02, i + 1 + skip);
                default: bench_mem[i] = enc_j(6'h03, i + 1 + skip);
            endcase
        end
        for (int i = 512; i < 576; i++) bench_mem[i] = $urandom;
        sync_mem();
        min_wait = 0; max_wait = 2;
        repeat (150) run_instr();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_cycle_data_path.md
MULTI_CYCLE_DATA_PATH -- requirements
Module: multi_cycle_data_path

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of PC and memory address (16..32).
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mem_addr  output  ADDR_WIDTH  byte address of the current memory request.
REQ-006 mem_wdata  output  32  store data, valid while mem_wr=1.
REQ-007 mem_rd, mem_wr  output  1 each  request strobes, mutually exclusive; "mem_req" below means mem_rd|mem_wr.
REQ-008 mem_rdata  input  32  fetch/load data, sampled on the edge where mem_ready=1.
REQ-009 mem_ready  input  1  completes the pending request at that rising edge.
REQ-010 state  output  3  current FSM state (encoding in REQ-014).
REQ-011 halted  output  1  high once an illegal instruction is decoded.
REQ-012 retired  output  32  count of completed instructions.

Function
REQ-013 The block SHALL contain the datapath and controller: PC, IR, 32x32 register file (r0 reads 0, writes ignored), ALU, sign-extend, and A/B/ALUOut/MDR holding registers.
REQ-014 FSM states SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
REQ-015 FETCH: mem_rd=1, mem_addr=PC; on mem_ready, IR<=mem_rdata, PC<=PC+4, go to DECODE; otherwise stay with outputs stable.
REQ-016 DECODE: A<=rs, B<=rt; j: PC<={PC[top:28],target,00} (truncated to ADDR_WIDTH), retire, go to FETCH; jal: same plus r31<=PC (already +4); jr: PC<=rs value, retire, go to FETCH; illegal opcode/funct: go to HALT; else go to EXECUTE.
REQ-017 Supported: R-type add(0x20) sub(0x22) and(0x24) or(0x25) slt(0x2A, signed) jr(0x08); addi(0x08) beq(0x04) lw(0x23) sw(0x2B) j(0x02) jal(0x03); all arithmetic is 32-bit, overflow ignored, wraps.
REQ-018 EXECUTE: R-type/addi: ALUOut<=result, go to WRITEBACK; lw/sw: ALUOut<=A+sext(imm), go to MEMORY; beq: if A==B then PC<=PC+(sext(imm)<<2), retire, go to FETCH.
REQ-019 MEMORY: mem_addr=ALUOut[ADDR_WIDTH-1:0]; lw: mem_rd=1, on mem_ready MDR<=mem_rdata, go to WRITEBACK; sw: mem_wr=1, mem_wdata=B, on mem_ready retire, go to FETCH; stall while mem_ready=0.
REQ-020 WRITEBACK: R-type writes ALUOut to rd, addi writes ALUOut to rt, lw writes MDR to rt; retire; go to FETCH.
REQ-021 Cycle counts with mem_ready tied high: j/jal/jr 2, beq 3, R-type/addi 4, sw 4, lw 5; each memory wait cycle adds 1.
REQ-022 mem_req SHALL be 0 in DECODE, EXECUTE, WRITEBACK, HALT; mem_ready is ignored when mem_req=0.
REQ-023 Address/strobes/wdata SHALL be held stable from request assertion until the mem_ready edge.
REQ-024 HALT is terminal: no register, PC, or memory activity, halted=1, until reset.
REQ-025 retired SHALL increment by exactly 1 on the retiring edge and wrap from 0xFFFFFFFF to 0.

Reset
REQ-026 rst=0 SHALL immediately force state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, halted=0, retired=0, mem_wr=0, and all 32 registers to 0.
REQ-027 Reset asserted mid-request SHALL abandon the transfer with no register write; after release, FETCH issues mem_rd at RESET_PC on the first cycle.

Verification
REQ-028 Reset, mem_ready=1, memory word 0 = addi r1,r0,5 -> after 4 cycles r1=5, retired=1, PC=4.
REQ-029 add r3,r1,r2 with r1=0x7FFFFFFF, r2=1 -> r3=0x80000000; slt r4,r3,r1 -> r4=1.
REQ-030 sw r1,8(r0) then lw r5,8(r0), with mem_ready held low 3 cycles per request -> write to addr 8 of 5, r5=5, lw takes 5+3+3 cycles, strobes stable while waiting.
REQ-031 beq r0,r0,-1 at PC=0x10 -> PC=0x10 again each 3 cycles; jal at 0x20 -> r31=0x24; jr r31 -> PC=0x24.
REQ-032 Opcode 0x3F fetched -> state=5, halted=1, mem_rd/mem_wr stay 0, retired frozen; rst pulse -> state=0, PC=RESET_PC.
REQ-033 rst asserted during lw MEMORY wait -> target register unchanged, retired=0, FETCH restarts at RESET_PC.
